// File: rtl/load_a2d_intf.sv
//------------------------------------------------------------------------------
// Module      : load_a2d_intf
// Description : Round-robin SPI reader for the left/right load-cell and battery
//               A2D channels. Optional macro LOAD_CELL_AVG_EN enables load-cell
//               averaging.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module load_a2d_intf #(
    parameter logic [2:0] LFT_CH  = 3'd0,
    parameter logic [2:0] RGHT_CH = 3'd4,
    parameter logic [2:0] BATT_CH = 3'd5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nxt,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] batt,
    output logic        vld
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CMD  = 3'd1;
    localparam logic [2:0] S_GAP  = 3'd2;
    localparam logic [2:0] S_READ = 3'd3;
    localparam logic [2:0] S_UPD  = 3'd4;

    localparam logic [4:0] c_div_init  = 5'b10111;
    localparam logic [4:0] c_div_rise  = 5'b01111;
    localparam logic [4:0] c_div_fall  = 5'b11111;
    localparam logic [4:0] c_num_smpl  = 5'd16;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic        r_ss_n;
    logic [4:0]  r_div;
    logic [15:0] r_shft;
    logic [11:0] r_rx;
    logic [4:0]  r_smpl_cnt;
    logic [1:0]  r_ptr;
    logic [11:0] r_lft_ld;
    logic [11:0] r_rght_ld;
    logic [11:0] r_batt;
    logic        r_vld;

    logic        w_smpl;
    logic        w_fall;
    logic        w_done;
    logic        w_shft;
    logic        w_start;
    logic        w_end;
    logic        w_upd;
    logic [15:0] w_cmd;
    logic [2:0]  w_chnl;
    logic [11:0] w_lft_new;
    logic [11:0] w_rght_new;

    assign w_smpl = ~r_ss_n && (r_div == c_div_rise);
    assign w_fall = ~r_ss_n && (r_div == c_div_fall);
    assign w_done = w_fall && (r_smpl_cnt == c_num_smpl);
    // The fall before any sample only frames the first bit, so it never shifts.
    assign w_shft = w_fall && (r_smpl_cnt != 5'd0);

    always_comb begin
        case (r_ptr)
            2'd0:    w_chnl = LFT_CH;
            2'd1:    w_chnl = RGHT_CH;
            default: w_chnl = BATT_CH;
        endcase
    end

`ifdef LOAD_CELL_AVG_EN
    logic [12:0] w_lft_sum;
    logic [12:0] w_rght_sum;

    assign w_lft_sum  = {1'b0, r_lft_ld}  + {1'b0, r_rx};
    assign w_rght_sum = {1'b0, r_rght_ld} + {1'b0, r_rx};
    assign w_lft_new  = w_lft_sum[12:1];
    assign w_rght_new = w_rght_sum[12:1];
`else
    assign w_lft_new  = r_rx;
    assign w_rght_new = r_rx;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_end       = 1'b0;
        w_upd       = 1'b0;
        w_cmd       = 16'h0000;
        case (r_state)
            S_IDLE: begin
                if (nxt) begin
                    w_state_nxt = S_CMD;
                    w_start     = 1'b1;
                    w_cmd       = {2'b00, w_chnl, 11'h000};
                end
            end
            S_CMD: begin
                if (w_done) begin
                    w_state_nxt = S_GAP;
                    w_end       = 1'b1;
                end
            end
            S_GAP: begin
                w_state_nxt = S_READ;
                w_start     = 1'b1;
            end
            S_READ: begin
                if (w_done) begin
                    w_state_nxt = S_UPD;
                    w_end       = 1'b1;
                end
            end
            S_UPD: begin
                w_state_nxt = S_IDLE;
                w_upd       = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ss_n     <= 1'b1;
            r_div      <= c_div_init;
            r_shft     <= 16'h0000;
            r_rx       <= 12'h000;
            r_smpl_cnt <= 5'd0;
            r_ptr      <= 2'd0;
            r_lft_ld   <= 12'h000;
            r_rght_ld  <= 12'h000;
            r_batt     <= 12'h000;
            r_vld      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_vld   <= w_upd;
            if (w_start) begin
                r_ss_n     <= 1'b0;
                r_div      <= c_div_init;
                r_shft     <= w_cmd;
                r_smpl_cnt <= 5'd0;
            end else if (w_end) begin
                r_ss_n <= 1'b1;
            end else if (~r_ss_n) begin
                r_div <= r_div + 5'd1;
                // Only the low 12 of the 16 shifted-in bits are retained.
                if (w_smpl) begin
                    r_rx       <= {r_rx[10:0], MISO};
                    r_smpl_cnt <= r_smpl_cnt + 5'd1;
                end
                if (w_shft) begin
                    r_shft <= {r_shft[14:0], 1'b0};
                end
            end
            if (w_upd) begin
                case (r_ptr)
                    2'd0:    r_lft_ld  <= w_lft_new;
                    2'd1:    r_rght_ld <= w_rght_new;
                    default: r_batt    <= r_rx;
                endcase
                r_ptr <= (r_ptr == 2'd2) ? 2'd0 : r_ptr + 2'd1;
            end
        end
    end

    assign SS_n    = r_ss_n;
    assign SCLK    = r_ss_n | r_div[4];
    assign MOSI    = r_shft[15];
    assign lft_ld  = r_lft_ld;
    assign rght_ld = r_rght_ld;
    assign batt    = r_batt;
    assign vld     = r_vld;

endmodule

`default_nettype wire
